// File: rtl/fma_result_writeback.sv
// fma_result_writeback: captures RoPE and norm result vectors into two slots and
// streams each one to SRAM as NBEAT beats (norm has priority over rope).
module fma_result_writeback #(
  parameter int BW_FP      = 17,
  parameter int VALUE_MN   = 64,
  parameter int BEAT_ELEMS = 32,
  parameter int AW         = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rope_valid,
  input  logic [2*VALUE_MN*BW_FP-1:0]   rope_data,
  input  logic                          norm_valid,
  input  logic [2*VALUE_MN*BW_FP-1:0]   norm_data,
  input  logic [AW-1:0]                 rope_base,
  input  logic [AW-1:0]                 norm_base,
  input  logic                          wr_ready,
  input  logic                          clear_ovf,
  output logic                          wr_en,
  output logic [AW-1:0]                 wr_addr,
  output logic [BEAT_ELEMS*BW_FP-1:0]   wr_data,
  output logic                          wr_src,
  output logic                          done,
  output logic                          busy,
  output logic [1:0]                    overflow
);
  localparam int NBEAT = 2*VALUE_MN/BEAT_ELEMS;
  localparam int VW    = 2*VALUE_MN*BW_FP;
  localparam int BBW   = BEAT_ELEMS*BW_FP;
  localparam int BCW   = NBEAT > 1 ? $clog2(NBEAT) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t                    r_state, w_next;
  logic [VW-1:0]             r_norm, r_rope;
  logic                      r_norm_pend, r_rope_pend;
  logic [BCW-1:0]            r_beat;
  logic [AW-1:0]             r_addr;
  logic                      r_src, r_done;
  logic [1:0]                r_ovf;
  logic                      w_accept, w_last, w_start, w_norm_free, w_rope_free;
  logic [NBEAT-1:0][BBW-1:0] w_beats;
  always_comb begin
    w_accept    = r_state == SEND && wr_ready;
    w_last      = w_accept && r_beat == BCW'(NBEAT-1);
    w_start     = r_state == IDLE && (r_norm_pend || r_rope_pend);
    w_next      = w_start ? SEND : w_last ? IDLE : r_state;
    // a slot whose final beat is being accepted this cycle can take a new vector
    w_norm_free = !r_norm_pend || (w_last && !r_src);
    w_rope_free = !r_rope_pend || (w_last && r_src);
    w_beats     = r_src ? r_rope : r_norm;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_norm      <= '0;
      r_rope      <= '0;
      r_norm_pend <= 1'b0;
      r_rope_pend <= 1'b0;
      r_ovf       <= 2'b00;
      r_beat      <= '0;
      r_addr      <= '0;
      r_src       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (norm_valid && w_norm_free) r_norm <= norm_data;
      if (rope_valid && w_rope_free) r_rope <= rope_data;
      r_norm_pend <= norm_valid || (r_norm_pend && !(w_last && !r_src));
      r_rope_pend <= rope_valid || (r_rope_pend && !(w_last && r_src));
      r_ovf       <= (clear_ovf ? 2'b00 : r_ovf) |
                     {rope_valid && !w_rope_free, norm_valid && !w_norm_free};
      if (w_start) begin
        r_beat <= '0;
        r_addr <= r_norm_pend ? norm_base : rope_base;
        r_src  <= !r_norm_pend;
      end else if (w_accept) begin
        r_beat <= r_beat + 1'b1;
        r_addr <= r_addr + 1'b1;
      end
      r_done <= w_last;
    end
  end
  assign wr_en    = r_state == SEND;
  assign wr_addr  = r_addr;
  assign wr_data  = r_state == SEND ? w_beats[r_beat] : '0;
  assign wr_src   = r_src;
  assign done     = r_done;
  assign busy     = r_state == SEND || r_norm_pend || r_rope_pend;
  assign overflow = r_ovf;
endmodule

// File: doc/fma_result_writeback.md
FMA_RESULT_WRITEBACK -- requirements
Module: fma_result_writeback

Interface
REQ-001 Parameters SHALL be, one per line:
  - BW_FP, 17, element width in bits
  - VALUE_MN, 64, elements per half-vector; a result vector is 2*VALUE_MN elements
  - BEAT_ELEMS, 32, elements per SRAM write beat; 2*VALUE_MN % BEAT_ELEMS == 0
  - AW, 10, SRAM word address width
REQ-002 NBEAT SHALL equal 2*VALUE_MN/BEAT_ELEMS (default 4); VW SHALL equal 2*VALUE_MN*BW_FP.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  - clk  in  1  single clock, rising edge
  - rst  in  1  asynchronous, active-high reset
  - rope_valid  in  1  one-cycle pulse, RoPE result vector ready
  - rope_data  in  VW  RoPE result vector
  - norm_valid  in  1  one-cycle pulse, post-attn-norm scaled vector ready
  - norm_data  in  VW  norm result vector
  - rope_base  in  AW  start address for a RoPE vector
  - norm_base  in  AW  start address for a norm vector
  - wr_ready  in  1  SRAM accepts the current beat
  - clear_ovf  in  1  clears overflow
  - wr_en  out  1  beat valid
  - wr_addr  out  AW  beat address
  - wr_data  out  BEAT_ELEMS*BW_FP  beat payload
  - wr_src  out  1  0=norm, 1=rope
  - done  out  1  one-cycle pulse, vector fully written
  - busy  out  1  transfer active or slot pending
  - overflow  out  2  sticky; bit0=norm, bit1=rope
REQ-004 Clocking SHALL be one clock (clk); reset SHALL be asynchronous and active-high (rst).

Function
REQ-005 Two capture slots SHALL exist (norm, rope), each VW bits plus a pending flag.
REQ-006 A valid pulse with its slot not pending SHALL latch the data and set pending at that edge.
REQ-007 A valid pulse with its slot pending SHALL drop the data and set the matching overflow bit; slot contents SHALL be unchanged.
REQ-008 A valid pulse in the same cycle as that slot's final beat acceptance SHALL be captured without overflow; pending SHALL stay 1.
REQ-009 FSM states SHALL be IDLE and SEND.
REQ-010 IDLE -> SEND SHALL occur when any slot is pending. Selection: norm over rope. At the transition, beat counter := 0, wr_addr := selected base, wr_src := selected source.
REQ-011 In SEND, wr_en SHALL be 1 and wr_data SHALL be slot bits [beat*BEAT_ELEMS*BW_FP +: BEAT_ELEMS*BW_FP], element 0 in LSBs.
REQ-012 A beat SHALL be accepted when wr_en && wr_ready. While wr_ready=0, wr_addr, wr_data and wr_src SHALL be held stable.
REQ-013 On acceptance, beat SHALL increment and wr_addr SHALL increment modulo 2^AW (wrap, no error).
REQ-014 On acceptance of beat NBEAT-1: clear that slot's pending flag, go to IDLE, and assert done for exactly the following cycle.
REQ-015 In IDLE, wr_en SHALL be 0; there SHALL be at least one IDLE cycle between transfers.
REQ-016 Latency with wr_ready=1 SHALL be: valid at edge t -> wr_en at cycles t+2..t+NBEAT+1 -> done at t+NBEAT+2.
REQ-017 busy SHALL equal (state==SEND) | norm_pending | rope_pending.
REQ-018 clear_ovf SHALL zero overflow. A simultaneous new overflow event SHALL win (bit set).
REQ-019 base inputs SHALL be sampled only at IDLE->SEND; later changes SHALL NOT affect an in-flight vector.

Reset
REQ-020 rst=1 SHALL asynchronously force: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, wr_src=0, done=0, busy=0, overflow=0, both pending=0, beat=0.
REQ-021 Reset mid-transfer SHALL abort the transfer with no done pulse. After release, no beat SHALL be issued until a new valid pulse arrives.

Verification
REQ-022 Single RoPE vector, rope_base=0x010, wr_ready=1 -> wr_en for 4 cycles, addr 0x010..0x013, wr_src=1, data = rope_data slices 0..3, done at t+6.
REQ-023 norm_valid and rope_valid in the same cycle -> norm's 4 beats at norm_base, one IDLE cycle, then rope's 4 beats; two done pulses; overflow=0.
REQ-024 wr_ready=0 for 3 cycles while beat 1 is presented -> addr/data held; 7 wr_en cycles total; data order intact.
REQ-025 Second norm_valid while norm slot pending -> overflow=2'b01; the first vector is written unaltered; clear_ovf -> overflow=0.
REQ-026 norm_base=0x3FE (AW=10) -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-027 rst pulse after beat 2 accepted -> all outputs zero immediately; no done; no wr_en until the next valid.
